// File: rtl/seg_scan_bcd.sv
// Binary-to-BCD display driver: sequential double-dabble conversion into a
// held display register, scanned across GROUPS segment buses with DP, blanking and overflow.
module seg_scan_bcd #(
  parameter  int unsigned DIGITS   = 8,
  parameter  int unsigned GROUPS   = 2,
  parameter  int unsigned BIN_W    = 32,
  parameter  int unsigned SCAN_DIV = 1,
  localparam int unsigned DPW      = $clog2(DIGITS) + 1
) (
  input  logic                  freq_source,
  input  logic                  rst,
  input  logic [BIN_W-1:0]      bin_in,
  input  logic                  load,
  input  logic [DPW-1:0]        dp_pos,
  input  logic                  blank_lz,
  output logic                  busy,
  output logic                  done,
  output logic                  ovf,
  output logic [GROUPS*8-1:0]   seg_out,
  output logic [DIGITS-1:0]     an_out
);

  localparam int unsigned DPG = DIGITS / GROUPS;
  localparam int unsigned BW  = DIGITS * 4;
  localparam int unsigned IW  = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int unsigned PW  = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int unsigned CW  = $clog2(BIN_W + 1);

  typedef enum logic {S_IDLE, S_CONV} state_t;

  state_t              state_q, state_d;
  logic [BIN_W-1:0]    sr_q, sr_d;
  logic [BW-1:0]       bcd_q, bcd_d;
  logic [BW-1:0]       disp_q, disp_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic                ovf_acc_q, ovf_acc_d;
  logic                ovf_q, ovf_d;
  logic                done_q, done_d;
  logic [PW-1:0]       presc_q, presc_d;
  logic [IW-1:0]       idx_q, idx_d;
  logic [GROUPS*8-1:0] seg_q, seg_d;
  logic [DIGITS-1:0]   an_q, an_d;

  logic [BW-1:0]       adj;
  logic [BW-1:0]       bcd_shift;
  logic                carry_out;
  logic [3:0]          cur_dig;
  logic                upper_zero;
  logic                run_zero;
  int unsigned         grp;
  logic                dp_hit;
  logic                blank;
  logic [7:0]          seg_byte;

  function automatic logic [6:0] glyph(input logic [3:0] v);
    case (v)
      4'd0:    glyph = 7'h3F;
      4'd1:    glyph = 7'h06;
      4'd2:    glyph = 7'h5B;
      4'd3:    glyph = 7'h4F;
      4'd4:    glyph = 7'h66;
      4'd5:    glyph = 7'h6D;
      4'd6:    glyph = 7'h7D;
      4'd7:    glyph = 7'h07;
      4'd8:    glyph = 7'h7F;
      4'd9:    glyph = 7'h6F;
      default: glyph = 7'h00;
    endcase
  endfunction

  always_ff @(posedge freq_source or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      sr_q      <= '0;
      bcd_q     <= '0;
      disp_q    <= '0;
      cnt_q     <= '0;
      ovf_acc_q <= 1'b0;
      ovf_q     <= 1'b0;
      done_q    <= 1'b0;
      presc_q   <= '0;
      idx_q     <= '0;
      seg_q     <= '0;
      an_q      <= '0;
    end else begin
      state_q   <= state_d;
      sr_q      <= sr_d;
      bcd_q     <= bcd_d;
      disp_q    <= disp_d;
      cnt_q     <= cnt_d;
      ovf_acc_q <= ovf_acc_d;
      ovf_q     <= ovf_d;
      done_q    <= done_d;
      presc_q   <= presc_d;
      idx_q     <= idx_d;
      seg_q     <= seg_d;
      an_q      <= an_d;
    end
  end

  // Conversion FSM: add-3 adjust then shift one bit per cycle; publish on the last shift.
  always_comb begin
    state_d   = state_q;
    sr_d      = sr_q;
    bcd_d     = bcd_q;
    disp_d    = disp_q;
    cnt_d     = cnt_q;
    ovf_acc_d = ovf_acc_q;
    ovf_d     = ovf_q;
    done_d    = 1'b0;

    for (int unsigned i = 0; i < DIGITS; i++) begin
      adj[i*4 +: 4] = (bcd_q[i*4 +: 4] >= 4'd5) ? bcd_q[i*4 +: 4] + 4'd3 : bcd_q[i*4 +: 4];
    end
    bcd_shift = {adj[BW-2:0], sr_q[BIN_W-1]};
    carry_out = adj[BW-1];

    case (state_q)
      S_IDLE: begin
        if (load) begin
          sr_d      = bin_in;
          bcd_d     = '0;
          cnt_d     = '0;
          ovf_acc_d = 1'b0;
          state_d   = S_CONV;
        end
      end
      S_CONV: begin
        sr_d      = sr_q << 1;
        bcd_d     = bcd_shift;
        ovf_acc_d = ovf_acc_q | carry_out;
        cnt_d     = cnt_q + CW'(1);
        if (cnt_q == CW'(BIN_W - 1)) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
          disp_d  = bcd_shift;
          ovf_d   = ovf_acc_q | carry_out;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Scan path: prescaler, digit index and the registered segment/anode image.
  always_comb begin
    presc_d = presc_q + PW'(1);
    idx_d   = idx_q;
    if (presc_q == PW'(SCAN_DIV - 1)) begin
      presc_d = '0;
      idx_d   = (idx_q == IW'(DIGITS - 1)) ? '0 : idx_q + IW'(1);
    end

    cur_dig    = '0;
    upper_zero = 1'b0;
    grp        = 0;
    run_zero   = 1'b1;
    for (int i = int'(DIGITS) - 1; i >= 0; i--) begin
      run_zero = run_zero & (disp_q[i*4 +: 4] == 4'd0);
      if (idx_q == IW'(i)) begin
        cur_dig    = disp_q[i*4 +: 4];
        upper_zero = run_zero;
        grp        = int'(i) / DPG;
      end
    end

    dp_hit = (dp_pos == DPW'(idx_q));
    // A DP at or above this digit keeps it visible, so "0.5" never loses its leading zero.
    blank  = blank_lz && (idx_q != '0) && upper_zero &&
             ((dp_pos >= DPW'(DIGITS)) || (DPW'(idx_q) > dp_pos));

    if (ovf_q) begin
      seg_byte = 8'h40;
    end else begin
      seg_byte = {dp_hit, blank ? 7'h00 : glyph(cur_dig)};
    end

    seg_d = '0;
    for (int unsigned g = 0; g < GROUPS; g++) begin
      if (grp == g) begin
        seg_d[g*8 +: 8] = seg_byte;
      end
    end
    an_d = DIGITS'(1) << idx_q;
  end

  assign busy    = (state_q == S_CONV);
  assign done    = done_q;
  assign ovf     = ovf_q;
  assign seg_out = seg_q;
  assign an_out  = an_q;

endmodule
